// File: rtl/multi_pad_receiver.sv
// Shared-latch NES/SNES pad receiver: polls NUM_PADS pads over common latch/clock
// lines and publishes active-high button vectors with per-pad presence flags.
//
//   state | meaning
//   IDLE  | waiting for poll counter expiry, poll_req or pending request
//   LATCH | pad_latch high; bit 0 sampled on the last cycle
//   LOW   | pad_clk low half-period
//   HIGH  | pad_clk high half-period; bit k sampled on the last cycle
//   DONE  | publish buttons/presence, frame_valid pulse
module multi_pad_receiver #(
   parameter int NUM_PADS     = 2,
   parameter int NUM_BITS     = 12,
   parameter int POLL_CYCLES  = 833333,
   parameter int LATCH_CYCLES = 600,
   parameter int HALF_CYCLES  = 300
) (
   input  logic                         system_clk_50MHz,
   input  logic                         reset,
   input  logic                         poll_req,
   input  logic [NUM_PADS-1:0]          pad_data,
   output logic                         pad_latch,
   output logic                         pad_clk,
   output logic [NUM_PADS*NUM_BITS-1:0] buttons,
   output logic [NUM_PADS-1:0]          pad_present,
   output logic                         frame_valid,
   output logic                         busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LATCH = 3'd1;
   localparam logic [2:0] LOW   = 3'd2;
   localparam logic [2:0] HIGH  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam int POLL_W = $clog2(POLL_CYCLES + 1);
   localparam int TMR_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
   localparam int TMR_W = $clog2(TMR_MAX + 1);
   localparam int BIT_W = $clog2(NUM_BITS + 1);
   localparam int NPB = NUM_PADS * NUM_BITS;

   localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_CYCLES - 1);
   localparam logic [TMR_W-1:0]  LATCH_TC = TMR_W'(LATCH_CYCLES - 1);
   localparam logic [TMR_W-1:0]  HALF_TC  = TMR_W'(HALF_CYCLES - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(NUM_BITS - 1);

   logic [2:0]          state_q, state_d;
   logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                pending_q, pending_d;
   logic [NUM_PADS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [NPB-1:0]      shift_q, shift_d;
   logic [NPB-1:0]      buttons_q, buttons_d;
   logic [NUM_PADS-1:0] present_q, present_d;
   logic                pad_latch_q, pad_latch_d;
   logic                pad_clk_q, pad_clk_d;
   logic                busy_q, busy_d;
   logic                frame_valid_q, frame_valid_d;
   logic                sample;

   always_comb begin
      state_d    = state_q;
      poll_cnt_d = (poll_cnt_q == POLL_MAX) ? poll_cnt_q : poll_cnt_q + POLL_W'(1);
      timer_d    = timer_q;
      bit_cnt_d  = bit_cnt_q;
      pending_d  = pending_q | (poll_req & (state_q != IDLE));
      sample     = 1'b0;
      case (state_q)
         IDLE: begin
            if ((poll_cnt_q == POLL_MAX) || poll_req || pending_q) begin
               state_d    = LATCH;
               poll_cnt_d = '0;
               pending_d  = 1'b0;
               timer_d    = LATCH_TC;
            end
         end
         LATCH: begin
            if (timer_q == '0) begin
               sample    = 1'b1;
               state_d   = LOW;
               timer_d   = HALF_TC;
               bit_cnt_d = BIT_W'(1);
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         LOW: begin
            if (timer_q == '0) begin
               state_d = HIGH;
               timer_d = HALF_TC;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         HIGH: begin
            if (timer_q == '0) begin
               sample = 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = DONE;
               end else begin
                  state_d   = LOW;
                  timer_d   = HALF_TC;
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-pad shift right so the first bit captured ends up at index 0
   always_comb begin
      sync1_d   = pad_data;
      sync2_d   = sync1_q;
      shift_d   = shift_q;
      buttons_d = buttons_q;
      present_d = present_q;
      if (sample) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            shift_d[p*NUM_BITS +: NUM_BITS] =
               {sync2_q[p], shift_q[p*NUM_BITS+1 +: NUM_BITS-1]};
         end
      end
      if (state_q == DONE) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            present_d[p] = |shift_q[p*NUM_BITS +: NUM_BITS];
            buttons_d[p*NUM_BITS +: NUM_BITS] = present_d[p] ?
               ~shift_q[p*NUM_BITS +: NUM_BITS] : '0;
         end
      end
      pad_latch_d   = (state_q == LATCH);
      pad_clk_d     = (state_q != LOW);
      busy_d        = (state_q != IDLE);
      frame_valid_d = (state_q == DONE);
   end

   always_ff @(posedge system_clk_50MHz) begin
      if (reset) begin
         state_q       <= IDLE;
         poll_cnt_q    <= '0;
         timer_q       <= '0;
         bit_cnt_q     <= '0;
         pending_q     <= 1'b0;
         sync1_q       <= '0;
         sync2_q       <= '0;
         shift_q       <= '0;
         buttons_q     <= '0;
         present_q     <= '0;
         pad_latch_q   <= 1'b0;
         pad_clk_q     <= 1'b1;
         busy_q        <= 1'b0;
         frame_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         poll_cnt_q    <= poll_cnt_d;
         timer_q       <= timer_d;
         bit_cnt_q     <= bit_cnt_d;
         pending_q     <= pending_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         shift_q       <= shift_d;
         buttons_q     <= buttons_d;
         present_q     <= present_d;
         pad_latch_q   <= pad_latch_d;
         pad_clk_q     <= pad_clk_d;
         busy_q        <= busy_d;
         frame_valid_q <= frame_valid_d;
      end
   end

   assign pad_latch   = pad_latch_q;
   assign pad_clk     = pad_clk_q;
   assign buttons     = buttons_q;
   assign pad_present = present_q;
   assign frame_valid = frame_valid_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_multi_pad_receiver.sv
// Bench for multi_pad_receiver: emulated pads driven from per-pad wire patterns,
// results compared against a pattern-level reference model.
module tb_multi_pad_receiver;
   localparam int NP = 2;
   localparam int NB = 12;
   localparam int POLL = 200;
   localparam int LAT = 4;
   localparam int HALF = 2;
   localparam int FRAME = LAT + 2*HALF*(NB-1) + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              poll_req;
   logic [NP-1:0]     pad_data;
   logic              pad_latch, pad_clk, frame_valid, busy;
   logic [NP*NB-1:0]  buttons;
   logic [NP-1:0]     pad_present;

   multi_pad_receiver #(.NUM_PADS(NP), .NUM_BITS(NB), .POLL_CYCLES(POLL),
                        .LATCH_CYCLES(LAT), .HALF_CYCLES(HALF)) dut (
      .system_clk_50MHz(clk), .reset(reset), .poll_req(poll_req), .pad_data(pad_data),
      .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
      .pad_present(pad_present), .frame_valid(frame_valid), .busy(busy));

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   // Pad emulation: latch reloads bit 0; data advances on pad_clk fall so it is
   // stable well before the receiver's sample point. Wire level = pattern bit.
   logic [NB-1:0] pat [NP];
   int   idx = NB;
   logic prev_pclk = 1'b1;
   always @(negedge clk) begin
      if (pad_latch) idx = 0;
      else if (prev_pclk && !pad_clk && idx < NB) idx++;
      prev_pclk = pad_clk;
      for (int p = 0; p < NP; p++) pad_data[p] = (idx < NB) ? pat[p][idx] : 1'b1;
   end

   function automatic logic [NP*NB-1:0] exp_buttons(logic [NB-1:0] w0, logic [NB-1:0] w1);
      logic [NB-1:0] b0, b1;
      b0 = (w0 == 0) ? '0 : ~w0;
      b1 = (w1 == 0) ? '0 : ~w1;
      return {b1, b0};
   endfunction

   function automatic logic [NP-1:0] exp_present(logic [NB-1:0] w0, logic [NB-1:0] w1);
      return {w1 != 0, w0 != 0};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pulses poll_req; n counts cycles after the start edge.
   task automatic run_frame(output int cyc, output int lat_first, output int lat_cnt,
                            output int falls);
      logic pc;
      @(negedge clk); poll_req = 1'b1;
      @(negedge clk); poll_req = 1'b0;
      cyc = 0; lat_first = -1; lat_cnt = 0; falls = 0; pc = pad_clk;
      while (!frame_valid && cyc < FRAME + 20) begin
         @(negedge clk);
         cyc++;
         if (pad_latch) begin
            lat_cnt++;
            if (lat_first < 0) lat_first = cyc;
         end
         if (pc && !pad_clk) falls++;
         pc = pad_clk;
      end
      if (!frame_valid) begin
         errs++;
         $display("FAIL frame_timeout: no frame_valid within %0d cycles", cyc);
      end
   endtask

   task automatic apply(string name, logic [NB-1:0] w0, logic [NB-1:0] w1, bit timing);
      int cyc, lf, lc, fl;
      logic [NP*NB-1:0] held;
      pat[0] = w0; pat[1] = w1;
      run_frame(cyc, lf, lc, fl);
      check({name, "_buttons"}, 32'(buttons), 32'(exp_buttons(w0, w1)));
      check({name, "_present"}, 32'(pad_present), 32'(exp_present(w0, w1)));
      check({name, "_frame_len"}, cyc, FRAME);
      if (timing) begin
         check({name, "_latch_start"}, lf, 1);
         check({name, "_latch_len"}, lc, LAT);
         check({name, "_clk_pulses"}, fl, NB-1);
      end
      held = buttons;
      @(negedge clk);
      check({name, "_fv_pulse"}, 32'(frame_valid), 0);
      check({name, "_hold"}, 32'(buttons), 32'(held));
   endtask

   typedef struct {
      logic [NB-1:0]    w0;
      logic [NB-1:0]    w1;
      logic [NP*NB-1:0] eb;
      logic [NP-1:0]    ep;
   } vec_t;
   vec_t tbl [5];

   int n;
   int q [$];
   int fv_cnt;
   logic [NB-1:0] r0, r1;
   logic pc;

   initial begin
      tbl[0] = '{12'h5A3, 12'hFFF, 24'h000A5C, 2'b11};
      tbl[1] = '{12'h5A3, 12'h000, 24'h000A5C, 2'b01};
      tbl[2] = '{12'h000, 12'h000, 24'h000000, 2'b00};
      tbl[3] = '{12'hFFE, 12'h001, 24'hFFE001, 2'b11};
      tbl[4] = '{12'h800, 12'h7FF, 24'h8007FF, 2'b11};

      pat[0] = 12'hFFF; pat[1] = 12'hFFF;
      reset = 1'b1; poll_req = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_latch", 32'(pad_latch), 0);
      check("rst_clk", 32'(pad_clk), 1);
      check("rst_buttons", 32'(buttons), 0);
      check("rst_present", 32'(pad_present), 0);
      check("rst_fv", 32'(frame_valid), 0);
      check("rst_busy", 32'(busy), 0);

      reset = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!pad_latch && n < 400);
      check("auto_first_latch", n, POLL + 1);
      n = 0;
      while (!frame_valid && n < 100) begin @(negedge clk); n++; end
      check("auto_fv_delay", n, FRAME - 1);
      check("auto_buttons", 32'(buttons), 0);
      check("auto_present", 32'(pad_present), 2'b11);

      for (int i = 0; i < 5; i++) begin
         apply($sformatf("tbl%0d", i), tbl[i].w0, tbl[i].w1, 1'b1);
         check($sformatf("tbl%0d_eb", i), 32'(buttons), 32'(tbl[i].eb));
         check($sformatf("tbl%0d_ep", i), 32'(pad_present), 32'(tbl[i].ep));
      end

      for (int i = 0; i < 16; i++) begin
         r0 = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
         r1 = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
         repeat ($urandom_range(0, 20)) @(negedge clk);
         apply($sformatf("rnd%0d", i), r0, r1, 1'b0);
      end

      // Requests mid-frame collapse to one back-to-back frame, then auto-poll
      pat[0] = 12'h5A3; pat[1] = 12'h0F0;
      @(negedge clk); poll_req = 1'b1;
      @(negedge clk); poll_req = 1'b0;
      n = 0;
      while (n < 320) begin
         @(negedge clk);
         n++;
         if (frame_valid) q.push_back(n);
         poll_req = (n == 10 || n == 20 || n == 30);
      end
      check("pend_count", q.size(), 3);
      check("pend_fv0", (q.size() > 0) ? q[0] : -1, FRAME);
      check("pend_fv1", (q.size() > 1) ? q[1] : -1, 2*FRAME + 1);
      check("pend_fv2", (q.size() > 2) ? q[2] : -1, FRAME + 1 + POLL + FRAME);
      check("pend_buttons", 32'(buttons), 32'(exp_buttons(12'h5A3, 12'h0F0)));

      // Reset during the fifth pad_clk low phase
      @(negedge clk); poll_req = 1'b1;
      @(negedge clk); poll_req = 1'b0;
      n = 0; fv_cnt = 0; pc = pad_clk;
      while (fv_cnt < 5 && n < 60) begin
         @(negedge clk);
         n++;
         if (pc && !pad_clk) fv_cnt++;
         pc = pad_clk;
      end
      check("abort_reached_low5", fv_cnt, 5);
      reset = 1'b1;
      @(negedge clk);
      check("abort_clk", 32'(pad_clk), 1);
      check("abort_latch", 32'(pad_latch), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_buttons", 32'(buttons), 0);
      check("abort_present", 32'(pad_present), 0);
      reset = 1'b0;
      fv_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (frame_valid) fv_cnt++;
      end
      check("abort_no_fv", fv_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
